// File: rtl/battleship_scoreboard_if.sv
// Result-word stream from the battleship core, plus the scoreboard's tallies and replay port to display/IO.
// The master drives the core/display side; the scoreboard attaches through the slave modport.
interface battleship_scoreboard_if;
   logic        new_game;
   logic        data_ready;
   logic [11:0] data_out;
   logic [4:0]  hits0;
   logic [4:0]  hits1;
   logic [6:0]  shots0;
   logic [6:0]  shots1;
   logic [2:0]  sunk0;
   logic [2:0]  sunk1;
   logic        turn;
   logic        turn_err;
   logic        game_over;
   logic        winner;
   logic        hist_pop;
   logic        hist_valid;
   logic [10:0] hist_data;
   logic        hist_ovf;

   modport master (
      output new_game, data_ready, data_out, hist_pop,
      input  hits0, hits1, shots0, shots1, sunk0, sunk1,
      input  turn, turn_err, game_over, winner,
      input  hist_valid, hist_data, hist_ovf
   );

   modport slave (
      input  new_game, data_ready, data_out, hist_pop,
      output hits0, hits1, shots0, shots1, sunk0, sunk1,
      output turn, turn_err, game_over, winner,
      output hist_valid, hist_data, hist_ovf
   );
endinterface

// File: rtl/battleship_scoreboard.sv
// Per-player shot/hit/sunk tallies, turn checking and end-of-game detection on the core's result stream.
// Replay FIFO is built only when SCOREBOARD_HISTORY_EN is defined; otherwise the hist_* outputs read 0.
module battleship_scoreboard #(
   parameter int HITS_TO_WIN = 17,
   parameter int HIST_DEPTH  = 8
) (
   input  logic                   ph1,
   input  logic                   reset,
   battleship_scoreboard_if.slave sb
);
   typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [4:0]  hits0_q, hits0_d, hits1_q, hits1_d;
   logic [6:0]  shots0_q, shots0_d, shots1_q, shots1_d;
   logic [2:0]  sunk0_q, sunk0_d, sunk1_q, sunk1_d;
   logic        turn_q, turn_d;
   logic        turn_err_q, turn_err_d;
   logic        winner_q, winner_d;

   logic        player;
   logic [1:0]  result;
   logic        scores_hit;
   logic        is_sunk;
   logic        accept;
   logic        win;
   logic [4:0]  cur_hits;
   logic        hist_valid_w;
   logic        hist_ovf_w;
   logic [10:0] hist_data_w;

   assign player     = sb.data_out[10];
   assign result     = sb.data_out[9:8];
   assign scores_hit = (result == 2'b01) || (result == 2'b10);
   assign is_sunk    = (result == 2'b10);
   assign cur_hits   = player ? hits1_q : hits0_q;
   // new_game takes priority over a word presented on the same edge
   assign accept     = sb.data_ready & sb.data_out[11] & (state_q == PLAY) & ~sb.new_game;
   assign win        = accept & scores_hit & (cur_hits == 5'(HITS_TO_WIN - 1));

   always_ff @(posedge ph1 or posedge reset) begin
      if (reset) begin
         state_q <= PLAY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (sb.new_game) begin
         state_d = PLAY;
      end else if (win) begin
         state_d = OVER;
      end
   end

   always_comb begin
      hits0_d    = hits0_q;
      hits1_d    = hits1_q;
      shots0_d   = shots0_q;
      shots1_d   = shots1_q;
      sunk0_d    = sunk0_q;
      sunk1_d    = sunk1_q;
      turn_d     = turn_q;
      turn_err_d = turn_err_q;
      winner_d   = winner_q;
      if (sb.new_game) begin
         hits0_d    = '0;
         hits1_d    = '0;
         shots0_d   = '0;
         shots1_d   = '0;
         sunk0_d    = '0;
         sunk1_d    = '0;
         turn_d     = 1'b0;
         turn_err_d = 1'b0;
         winner_d   = 1'b0;
      end else if (accept) begin
         if (!player) begin
            if (shots0_q != 7'd127) shots0_d = shots0_q + 7'd1;
            if (scores_hit)         hits0_d  = hits0_q + 5'd1;
            if (is_sunk && sunk0_q != 3'd7) sunk0_d = sunk0_q + 3'd1;
         end else begin
            if (shots1_q != 7'd127) shots1_d = shots1_q + 7'd1;
            if (scores_hit)         hits1_d  = hits1_q + 5'd1;
            if (is_sunk && sunk1_q != 3'd7) sunk1_d = sunk1_q + 3'd1;
         end
         if (player != turn_q) turn_err_d = 1'b1;
         turn_d = ~player;
         if (win) winner_d = player;
      end
   end

   always_ff @(posedge ph1 or posedge reset) begin
      if (reset) begin
         hits0_q    <= '0;
         hits1_q    <= '0;
         shots0_q   <= '0;
         shots1_q   <= '0;
         sunk0_q    <= '0;
         sunk1_q    <= '0;
         turn_q     <= 1'b0;
         turn_err_q <= 1'b0;
         winner_q   <= 1'b0;
      end else begin
         hits0_q    <= hits0_d;
         hits1_q    <= hits1_d;
         shots0_q   <= shots0_d;
         shots1_q   <= shots1_d;
         sunk0_q    <= sunk0_d;
         sunk1_q    <= sunk1_d;
         turn_q     <= turn_d;
         turn_err_q <= turn_err_d;
         winner_q   <= winner_d;
      end
   end

`ifdef SCOREBOARD_HISTORY_EN
   localparam int AW = $clog2(HIST_DEPTH);

   logic [10:0] mem_q [HIST_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        ovf_q, ovf_d;
   logic        empty, full, do_pop, do_push;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = sb.hist_pop & ~empty;
   // a pop on the same edge frees the slot the push needs
   assign do_push = accept & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (sb.new_game) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ovf_d    = 1'b0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         if (accept && !do_push) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge ph1 or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge ph1) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= sb.data_out[10:0];
   end

   assign hist_valid_w = ~empty;
   assign hist_ovf_w   = ovf_q;
   assign hist_data_w  = empty ? 11'd0 : mem_q[rd_ptr_q[AW-1:0]];
`else
   logic unused_hist;

   assign hist_valid_w = 1'b0;
   assign hist_ovf_w   = 1'b0;
   assign hist_data_w  = 11'd0;
   assign unused_hist  = sb.hist_pop & (^sb.data_out[7:0]) & (HIST_DEPTH > 0);
`endif

   always_comb begin
      sb.hits0      = hits0_q;
      sb.hits1      = hits1_q;
      sb.shots0     = shots0_q;
      sb.shots1     = shots1_q;
      sb.sunk0      = sunk0_q;
      sb.sunk1      = sunk1_q;
      sb.turn       = turn_q;
      sb.turn_err   = turn_err_q;
      sb.winner     = winner_q;
      sb.game_over  = (state_q == OVER);
      sb.hist_valid = hist_valid_w;
      sb.hist_data  = hist_data_w;
      sb.hist_ovf   = hist_ovf_w;
   end
endmodule

// File: tb/tb_battleship_scoreboard.sv
// Directed bench for battleship_scoreboard: vector table plus hand sequences for game end, saturation, async reset and history.
module tb_battleship_scoreboard;
   logic ph1 = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;

   battleship_scoreboard_if bif();

   battleship_scoreboard #(.HITS_TO_WIN(17), .HIST_DEPTH(8)) dut (
      .ph1   (ph1),
      .reset (reset),
      .sb    (bif)
   );

   always #5 ph1 = ~ph1;

   typedef struct {
      string       name;
      logic        ng;
      logic        dr;
      logic [11:0] d;
      logic [4:0]  h0, h1;
      logic [6:0]  s0, s1;
      logic [2:0]  k0, k1;
      logic        turn, terr, go, win;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ng, input logic dr, input logic [11:0] d, input logic pop);
      bif.new_game   = ng;
      bif.data_ready = dr;
      bif.data_out   = d;
      bif.hist_pop   = pop;
   endtask

   task automatic tick();
      @(posedge ph1);
      #1;
   endtask

   task automatic chk_all(input string tag,
                          input logic [4:0] h0, input logic [4:0] h1,
                          input logic [6:0] s0, input logic [6:0] s1,
                          input logic [2:0] k0, input logic [2:0] k1,
                          input logic turn, input logic terr, input logic go, input logic win);
      chk({tag, ".hits0"},     32'(bif.hits0),     32'(h0));
      chk({tag, ".hits1"},     32'(bif.hits1),     32'(h1));
      chk({tag, ".shots0"},    32'(bif.shots0),    32'(s0));
      chk({tag, ".shots1"},    32'(bif.shots1),    32'(s1));
      chk({tag, ".sunk0"},     32'(bif.sunk0),     32'(k0));
      chk({tag, ".sunk1"},     32'(bif.sunk1),     32'(k1));
      chk({tag, ".turn"},      32'(bif.turn),      32'(turn));
      chk({tag, ".turn_err"},  32'(bif.turn_err),  32'(terr));
      chk({tag, ".game_over"}, 32'(bif.game_over), 32'(go));
      chk({tag, ".winner"},    32'(bif.winner),    32'(win));
   endtask

   function automatic logic [11:0] hist_word(input int i);
      return {1'b1, 1'b0, 2'b00, 4'(i), 4'(i)};
   endfunction

   initial begin
      // name, ng, dr, word, hits0/1, shots0/1, sunk0/1, turn, turn_err, game_over, winner
      vecs[0] = '{"p1_miss_first",    1'b0, 1'b1, 12'hC34, 5'd0, 5'd0, 7'd0, 7'd1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{"new_game_drops",   1'b1, 1'b1, 12'h911, 5'd0, 5'd0, 7'd0, 7'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{"p0_sunk",          1'b0, 1'b1, 12'hA55, 5'd1, 5'd0, 7'd1, 7'd0, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{"p0_repeat",        1'b0, 1'b1, 12'hB55, 5'd1, 5'd0, 7'd2, 7'd0, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{"non_shot_ignored", 1'b0, 1'b1, 12'h355, 5'd1, 5'd0, 7'd2, 7'd0, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{"not_ready",        1'b0, 1'b0, 12'hC22, 5'd1, 5'd0, 7'd2, 7'd0, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{"p1_miss",          1'b0, 1'b1, 12'hC22, 5'd1, 5'd0, 7'd2, 7'd1, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{"new_game_clear",   1'b1, 1'b0, 12'h000, 5'd0, 5'd0, 7'd0, 7'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};

      reset = 1'b1;
      drive(1'b0, 1'b0, 12'h000, 1'b0);
      #12;
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset.hist_valid", 32'(bif.hist_valid), 0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].ng, vecs[i].dr, vecs[i].d, 1'b0);
         tick();
         chk_all(vecs[i].name, vecs[i].h0, vecs[i].h1, vecs[i].s0, vecs[i].s1,
                 vecs[i].k0, vecs[i].k1, vecs[i].turn, vecs[i].terr, vecs[i].go, vecs[i].win);
      end

      // player 0 hits every turn; the 17th hit ends the game before player 1's reply
      for (int r = 1; r <= 17; r++) begin
         drive(1'b0, 1'b1, 12'h911, 1'b0);
         tick();
         drive(1'b0, 1'b1, 12'hC22, 1'b0);
         tick();
         if (r == 16) chk_all("p0_round16", 16, 0, 16, 16, 0, 0, 0, 0, 0, 0);
      end
      chk_all("p0_wins", 17, 0, 17, 16, 0, 0, 1, 0, 1, 0);
      drive(1'b0, 1'b1, 12'hC33, 1'b0);
      tick();
      chk_all("over_ignores", 17, 0, 17, 16, 0, 0, 1, 0, 1, 0);

      drive(1'b1, 1'b0, 12'h000, 1'b0);
      tick();
      for (int r = 1; r <= 17; r++) begin
         drive(1'b0, 1'b1, 12'h800, 1'b0);
         tick();
         drive(1'b0, 1'b1, 12'hD00, 1'b0);
         tick();
      end
      chk_all("p1_wins", 0, 17, 17, 17, 0, 0, 0, 0, 1, 1);

      drive(1'b1, 1'b0, 12'h000, 1'b0);
      tick();
      for (int r = 0; r < 8; r++) begin
         drive(1'b0, 1'b1, 12'hA00, 1'b0);
         tick();
      end
      chk_all("sunk_sat", 8, 0, 8, 0, 7, 0, 1, 1, 0, 0);
      for (int r = 0; r < 130; r++) begin
         drive(1'b0, 1'b1, 12'h800, 1'b0);
         tick();
      end
      chk_all("shots_sat", 8, 0, 127, 0, 7, 0, 1, 1, 0, 0);

`ifndef SCOREBOARD_HISTORY_EN
      drive(1'b0, 1'b0, 12'h000, 1'b1);
      tick();
      chk("nohist.valid", 32'(bif.hist_valid), 0);
      chk("nohist.data",  32'(bif.hist_data),  0);
      chk("nohist.ovf",   32'(bif.hist_ovf),   0);
`endif

      // asynchronous reset lands between edges with a word on the bus
      drive(1'b1, 1'b0, 12'h000, 1'b0);
      tick();
      drive(1'b0, 1'b1, 12'h911, 1'b0);
      tick();
      drive(1'b0, 1'b1, 12'hC22, 1'b0);
      tick();
      chk_all("pre_reset", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      drive(1'b0, 1'b1, 12'h911, 1'b0);
      #3 reset = 1'b1;
      #1;
      chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 reset = 1'b0;
      drive(1'b0, 1'b0, 12'h000, 1'b0);
      tick();
      chk_all("after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef SCOREBOARD_HISTORY_EN
      drive(1'b1, 1'b0, 12'h000, 1'b0);
      tick();
      for (int i = 1; i <= 9; i++) begin
         drive(1'b0, 1'b1, hist_word(i), 1'b0);
         tick();
      end
      chk("hist.ovf_set", 32'(bif.hist_ovf),   1);
      chk("hist.valid",   32'(bif.hist_valid), 1);
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("hist.pop%0d", i), 32'(bif.hist_data), 32'(hist_word(i) & 12'h7FF));
         drive(1'b0, 1'b0, 12'h000, 1'b1);
         tick();
      end
      chk("hist.empty", 32'(bif.hist_valid), 0);
      drive(1'b1, 1'b0, 12'h000, 1'b0);
      tick();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 1'b1, hist_word(i), 1'b0);
         tick();
      end
      chk("hist.full_no_ovf", 32'(bif.hist_ovf), 0);
      drive(1'b0, 1'b1, hist_word(9), 1'b1);
      tick();
      chk("hist.pushpop_ovf",  32'(bif.hist_ovf),  0);
      for (int i = 2; i <= 9; i++) begin
         chk($sformatf("hist.wrap%0d", i), 32'(bif.hist_data), 32'(hist_word(i) & 12'h7FF));
         drive(1'b0, 1'b0, 12'h000, 1'b1);
         tick();
      end
      chk("hist.wrap_empty", 32'(bif.hist_valid), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end
endmodule
